// File: rtl/mul_wb_arbiter_pkg.sv
// rtl/mul_wb_arbiter_pkg.sv - shared packet types and constants for the multiplier writeback arbiter
//
// Provides:
//   MUL_UNIT_NUM           number of multiplier execute units sharing the writeback port (fixed at 2)
//   execute_wb_pack_t      execute -> writeback result packet
//   commit_feedback_pack_t commit-stage feedback (enable/flush drive the arbiter flush)
package mul_wb_arbiter_pkg;

  localparam int MUL_UNIT_NUM     = 2;
  localparam int ROB_ID_WIDTH     = 6;
  localparam int PHY_REG_ID_WIDTH = 6;
  localparam int REG_DATA_WIDTH   = 32;

  typedef struct packed {
    logic                        enable;
    logic [ROB_ID_WIDTH-1:0]     rob_id;
    logic                        rd_enable;
    logic [PHY_REG_ID_WIDTH-1:0] rd_id;
    logic [REG_DATA_WIDTH-1:0]   rd_value;
  } execute_wb_pack_t;

  typedef struct packed {
    logic                    enable;
    logic [ROB_ID_WIDTH-1:0] next_handle_rob_id;
    logic                    flush;
  } commit_feedback_pack_t;

endpackage

// File: rtl/wb_skid_fifo.sv
// rtl/wb_skid_fifo.sv - small per-requester result buffer in front of the writeback arbiter
//
// Ports:
//   clk       clock
//   flush     synchronous clear of all entries (reset or commit flush)
//   push      write data_in (ignored while full)
//   pop       drop the head entry (ignored while empty)
//   data_in   packet to store
//   data_out  head packet (valid only when !empty)
//   empty     no entries held
//   full      DEPTH entries held; derived from the registered count only
module wb_skid_fifo
  import mul_wb_arbiter_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             flush,
  input  logic             push,
  input  logic             pop,
  input  execute_wb_pack_t data_in,
  output execute_wb_pack_t data_out,
  output logic             empty,
  output logic             full
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  execute_wb_pack_t   mem [DEPTH];
  logic [PTR_W-1:0]   rd_ptr;
  logic [PTR_W-1:0]   wr_ptr;
  logic [CNT_W-1:0]   count;
  logic               do_push;
  logic               do_pop;

  assign full     = (count == CNT_W'(DEPTH));
  assign empty    = (count == '0);
  assign do_push  = push & ~full;
  assign do_pop   = pop & ~empty;
  assign data_out = mem[rd_ptr];

  // DEPTH is a power of two, so pointer increments wrap on their own.
  always_ff @(posedge clk) begin
    if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      // Push and pop together leave the count unchanged; the new entry
      // lands behind the one being popped because wr_ptr != rd_ptr here.
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage is not reset: entries are only visible through count.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= data_in;
  end

endmodule

// File: rtl/mul_wb_arbiter.sv
// rtl/mul_wb_arbiter.sv - round-robin share of one writeback port between two multiplier units
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   mulN_wb_port_data_in     result packet from multiplier unit N
//   mulN_wb_port_we          unit N write request
//   mulN_wb_full             unit N buffer full; unit N must not write
//   wb_port_data_in          granted packet towards the writeback FIFO
//   wb_port_we               writeback FIFO write enable
//   wb_port_flush            writeback FIFO flush (reset or commit flush)
//   wb_port_full             writeback FIFO full; stalls the arbiter
//   commit_feedback_pack     commit feedback; enable & flush discards everything in flight
module mul_wb_arbiter
  import mul_wb_arbiter_pkg::*;
#(
  parameter int BUF_DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  execute_wb_pack_t      mul0_wb_port_data_in,
  input  logic                  mul0_wb_port_we,
  output logic                  mul0_wb_full,
  input  execute_wb_pack_t      mul1_wb_port_data_in,
  input  logic                  mul1_wb_port_we,
  output logic                  mul1_wb_full,
  output execute_wb_pack_t      wb_port_data_in,
  output logic                  wb_port_we,
  output logic                  wb_port_flush,
  input  logic                  wb_port_full,
  input  commit_feedback_pack_t commit_feedback_pack
);

  logic             flush_req;
  logic             buf_flush;
  logic             rr_ptr;
  logic             grant_valid;
  logic             grant_id;

  execute_wb_pack_t unit_data [MUL_UNIT_NUM];
  logic             unit_we   [MUL_UNIT_NUM];
  execute_wb_pack_t head      [MUL_UNIT_NUM];
  logic             buf_push  [MUL_UNIT_NUM];
  logic             buf_pop   [MUL_UNIT_NUM];
  logic             buf_empty [MUL_UNIT_NUM];
  logic             buf_full  [MUL_UNIT_NUM];

  // Only enable and flush of the commit feedback matter here.
  logic unused_commit_bits;
  assign unused_commit_bits = ^commit_feedback_pack.next_handle_rob_id;

  assign flush_req     = commit_feedback_pack.enable & commit_feedback_pack.flush;
  assign buf_flush     = rst | flush_req;
  assign wb_port_flush = rst | flush_req;

  assign unit_data[0] = mul0_wb_port_data_in;
  assign unit_data[1] = mul1_wb_port_data_in;
  assign unit_we[0]   = mul0_wb_port_we;
  assign unit_we[1]   = mul1_wb_port_we;
  assign mul0_wb_full = buf_full[0];
  assign mul1_wb_full = buf_full[1];

  for (genvar u = 0; u < MUL_UNIT_NUM; u++) begin : g_unit
    // A push in a flush or reset cycle is dropped, as is a write while full.
    assign buf_push[u] = unit_we[u] & unit_data[u].enable & ~buf_full[u] & ~flush_req & ~rst;
    assign buf_pop[u]  = wb_port_we & (grant_id == 1'(u));

    wb_skid_fifo #(
      .DEPTH (BUF_DEPTH)
    ) u_buf (
      .clk      (clk),
      .flush    (buf_flush),
      .push     (buf_push[u]),
      .pop      (buf_pop[u]),
      .data_in  (unit_data[u]),
      .data_out (head[u]),
      .empty    (buf_empty[u]),
      .full     (buf_full[u])
    );
  end

  // rr_ptr names the unit that wins when both buffers hold data. With no
  // candidate grant_id still follows rr_ptr so the output mux has a defined
  // (don't-care) selection.
  always_comb begin
    grant_valid = 1'b0;
    grant_id    = rr_ptr;
    if (!buf_empty[0] && !buf_empty[1]) begin
      grant_valid = 1'b1;
      grant_id    = rr_ptr;
    end else if (!buf_empty[0]) begin
      grant_valid = 1'b1;
      grant_id    = 1'b0;
    end else if (!buf_empty[1]) begin
      grant_valid = 1'b1;
      grant_id    = 1'b1;
    end
  end

  assign wb_port_we      = grant_valid & ~wb_port_full & ~flush_req & ~rst;
  assign wb_port_data_in = grant_id ? head[1] : head[0];

  // After a transfer the other unit gets priority; stalls leave rr_ptr alone.
  always_ff @(posedge clk) begin
    if (rst || flush_req) begin
      rr_ptr <= 1'b0;
    end else if (wb_port_we) begin
      rr_ptr <= ~grant_id;
    end
  end

endmodule

// File: tb/tb_mul_wb_arbiter.sv
// tb/tb_mul_wb_arbiter.sv - directed scoreboard bench for mul_wb_arbiter
module tb_mul_wb_arbiter;
  import mul_wb_arbiter_pkg::*;

  logic                  clk = 1'b0;
  logic                  rst;
  execute_wb_pack_t      mul0_wb_port_data_in;
  logic                  mul0_wb_port_we;
  logic                  mul0_wb_full;
  execute_wb_pack_t      mul1_wb_port_data_in;
  logic                  mul1_wb_port_we;
  logic                  mul1_wb_full;
  execute_wb_pack_t      wb_port_data_in;
  logic                  wb_port_we;
  logic                  wb_port_flush;
  logic                  wb_port_full;
  commit_feedback_pack_t commit_feedback_pack;

  always #5 clk = ~clk;

  mul_wb_arbiter #(.BUF_DEPTH(2)) dut (
    .clk                  (clk),
    .rst                  (rst),
    .mul0_wb_port_data_in (mul0_wb_port_data_in),
    .mul0_wb_port_we      (mul0_wb_port_we),
    .mul0_wb_full         (mul0_wb_full),
    .mul1_wb_port_data_in (mul1_wb_port_data_in),
    .mul1_wb_port_we      (mul1_wb_port_we),
    .mul1_wb_full         (mul1_wb_full),
    .wb_port_data_in      (wb_port_data_in),
    .wb_port_we           (wb_port_we),
    .wb_port_flush        (wb_port_flush),
    .wb_port_full         (wb_port_full),
    .commit_feedback_pack (commit_feedback_pack)
  );

  typedef struct {
    logic [31:0] val;
    logic [5:0]  rob;
  } exp_t;

  exp_t sb[$];
  int   vectors     = 0;
  int   miscompares = 0;

  function automatic execute_wb_pack_t mk(input logic [31:0] v, input logic [5:0] rob);
    execute_wb_pack_t p;
    p           = '0;
    p.enable    = 1'b1;
    p.rob_id    = rob;
    p.rd_enable = 1'b1;
    p.rd_id     = rob;
    p.rd_value  = v;
    return p;
  endfunction

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic expect_pkt(input logic [31:0] v, input logic [5:0] rob);
    exp_t e;
    e.val = v;
    e.rob = rob;
    sb.push_back(e);
  endtask

  // Every write to the writeback FIFO must match the scoreboard head.
  task automatic monitor();
    exp_t e;
    if (wb_port_we === 1'b1) begin
      if (sb.size() == 0) begin
        check_bit("unexpected_write", wb_port_we, 1'b0);
      end else begin
        e = sb.pop_front();
        check_val("wb_rd_value", wb_port_data_in.rd_value, e.val);
        check_val("wb_rob_id", 32'(wb_port_data_in.rob_id), 32'(e.rob));
      end
    end
  endtask

  // Inputs are driven 1 time unit after a rising edge; outputs are sampled
  // one more unit later, then the next edge is taken.
  task automatic cyc();
    #1;
    monitor();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    mul0_wb_port_we      = 1'b0;
    mul1_wb_port_we      = 1'b0;
    mul0_wb_port_data_in = '0;
    mul1_wb_port_data_in = '0;
    commit_feedback_pack = '0;
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    idle_inputs();
    wb_port_full = 1'b0;
    cyc();
    rst = 1'b0;
  endtask

  task automatic drain(input string tag, input int budget);
    for (int c = 0; c < budget && sb.size() > 0; c++) cyc();
    check_val(tag, 32'(sb.size()), 32'd0);
    sb.delete();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int  n0;
    int  n1;
    bit  saw_f0;
    bit  saw_f1;

    // Reset, with a unit 0 write attempt that must be discarded.
    rst          = 1'b1;
    wb_port_full = 1'b0;
    idle_inputs();
    mul0_wb_port_we      = 1'b1;
    mul0_wb_port_data_in = mk(32'd99, 6'd1);
    #1;
    check_bit("rst_flush", wb_port_flush, 1'b1);
    check_bit("rst_we", wb_port_we, 1'b0);
    cyc();
    cyc();
    rst = 1'b0;
    idle_inputs();
    #1;
    check_bit("post_rst_full0", mul0_wb_full, 1'b0);
    check_bit("post_rst_full1", mul1_wb_full, 1'b0);
    check_bit("post_rst_we", wb_port_we, 1'b0);
    check_bit("post_rst_flush", wb_port_flush, 1'b0);
    cyc();
    cyc();

    // Single packet from unit 0: visible the cycle after the push, then gone.
    reset_dut();
    mul0_wb_port_we      = 1'b1;
    mul0_wb_port_data_in = mk(32'd72, 6'd3);
    expect_pkt(32'd72, 6'd3);
    cyc();
    idle_inputs();
    #1;
    check_bit("single_we", wb_port_we, 1'b1);
    cyc();
    #1;
    check_bit("single_we_after", wb_port_we, 1'b0);
    drain("single_left", 2);

    // Both units stream 4 packets each; writes respect the full flags.
    reset_dut();
    expect_pkt(32'd1, 6'd0);  expect_pkt(32'd11, 6'd10);
    expect_pkt(32'd2, 6'd1);  expect_pkt(32'd12, 6'd11);
    expect_pkt(32'd3, 6'd2);  expect_pkt(32'd13, 6'd12);
    expect_pkt(32'd4, 6'd3);  expect_pkt(32'd14, 6'd13);
    n0 = 0; n1 = 0; saw_f0 = 1'b0; saw_f1 = 1'b0;
    for (int c = 0; c < 40 && sb.size() > 0; c++) begin
      if (mul0_wb_full === 1'b1) saw_f0 = 1'b1;
      if (mul1_wb_full === 1'b1) saw_f1 = 1'b1;
      mul0_wb_port_we = (n0 < 4) && (mul0_wb_full !== 1'b1);
      mul1_wb_port_we = (n1 < 4) && (mul1_wb_full !== 1'b1);
      if (mul0_wb_port_we) begin
        mul0_wb_port_data_in = mk(32'(n0 + 1), 6'(n0));
        n0++;
      end
      if (mul1_wb_port_we) begin
        mul1_wb_port_data_in = mk(32'(n1 + 11), 6'(n1 + 10));
        n1++;
      end
      cyc();
    end
    idle_inputs();
    check_val("stream_left", 32'(sb.size()), 32'd0);
    check_bit("stream_saw_full0", saw_f0, 1'b1);
    check_bit("stream_saw_full1", saw_f1, 1'b1);
    sb.delete();

    // Writeback FIFO stalled while both units fill their buffers.
    reset_dut();
    wb_port_full = 1'b1;
    for (int k = 0; k < 2; k++) begin
      mul0_wb_port_we      = 1'b1;
      mul1_wb_port_we      = 1'b1;
      mul0_wb_port_data_in = mk(32'(21 + k), 6'(20 + k));
      mul1_wb_port_data_in = mk(32'(31 + k), 6'(30 + k));
      cyc();
    end
    idle_inputs();
    #1;
    check_bit("stall_full0", mul0_wb_full, 1'b1);
    check_bit("stall_full1", mul1_wb_full, 1'b1);
    check_bit("stall_we", wb_port_we, 1'b0);
    expect_pkt(32'd21, 6'd20); expect_pkt(32'd31, 6'd30);
    expect_pkt(32'd22, 6'd21); expect_pkt(32'd32, 6'd31);
    wb_port_full = 1'b0;
    cyc();
    check_bit("release_full0", mul0_wb_full, 1'b0);
    check_bit("release_full1", mul1_wb_full, 1'b1);
    drain("stall_left", 10);

    // Commit flush with three packets buffered and a push in the flush cycle.
    reset_dut();
    wb_port_full         = 1'b1;
    mul0_wb_port_we      = 1'b1;
    mul1_wb_port_we      = 1'b1;
    mul0_wb_port_data_in = mk(32'd41, 6'd40);
    mul1_wb_port_data_in = mk(32'd51, 6'd50);
    cyc();
    mul1_wb_port_we      = 1'b0;
    mul0_wb_port_data_in = mk(32'd42, 6'd41);
    cyc();
    idle_inputs();
    wb_port_full                = 1'b0;
    commit_feedback_pack.enable = 1'b1;
    commit_feedback_pack.flush  = 1'b1;
    mul1_wb_port_we             = 1'b1;
    mul1_wb_port_data_in        = mk(32'd52, 6'd51);
    #1;
    check_bit("flush_cycle_flush", wb_port_flush, 1'b1);
    check_bit("flush_cycle_we", wb_port_we, 1'b0);
    cyc();
    idle_inputs();
    #1;
    check_bit("post_flush_we", wb_port_we, 1'b0);
    check_bit("post_flush_full0", mul0_wb_full, 1'b0);
    check_bit("post_flush_full1", mul1_wb_full, 1'b0);
    check_bit("post_flush_flush", wb_port_flush, 1'b0);
    for (int c = 0; c < 4; c++) cyc();

    // Unit 1 alone is granted with no bubble; priority then returns to unit 0.
    reset_dut();
    mul1_wb_port_we      = 1'b1;
    mul1_wb_port_data_in = mk(32'd61, 6'd9);
    expect_pkt(32'd61, 6'd9);
    cyc();
    idle_inputs();
    #1;
    check_bit("u1_alone_we", wb_port_we, 1'b1);
    cyc();
    mul0_wb_port_we      = 1'b1;
    mul1_wb_port_we      = 1'b1;
    mul0_wb_port_data_in = mk(32'd62, 6'd12);
    mul1_wb_port_data_in = mk(32'd63, 6'd13);
    expect_pkt(32'd62, 6'd12);
    expect_pkt(32'd63, 6'd13);
    cyc();
    idle_inputs();
    drain("rr_left", 6);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
